adc_sdo_reader: RTL and testbench
=================================

ADC_SDO_READER -- requirements
Module: adc_sdo_reader

Interface
REQ-001 Parameter CLK_DIV, default 2: ADC_SCK half-period in CLOCK_50 cycles; legal range 1..255.
REQ-002 Parameter CONVST_CYCLES, default 2: ADC_CONVST high width in CLOCK_50 cycles; legal range 1..255.
REQ-003 Parameter CONV_CYCLES, default 80: conversion wait after ADC_CONVST falls, in CLOCK_50 cycles; legal range 1..1023.
REQ-004 Parameter NUM_CH, default 13: channel sequence length for result tagging; legal range 1..16.
REQ-005 One clock; reset is asynchronous and active-low.
REQ-006 CLOCK_50  input  1  system clock; all state changes occur on its rising edge.
REQ-007 RESET_n  input  1  asynchronous active-low reset.
REQ-008 ENABLE  input  1  level; while high, frames run back-to-back.
REQ-009 ADC_SDO  input  1  serial result from the ADC, MSB first, updated by the ADC on ADC_SCK falling edges.
REQ-010 ADC_CONVST  output  1  conversion start to the ADC.
REQ-011 ADC_SCK  output  1  serial clock to the ADC; also drives the SDI configuration shifter.
REQ-012 FLAG  output  1  frame marker; its falling edge advances the external SDI channel sequencer.
REQ-013 DATA  output  12  last captured conversion result.
REQ-014 DATA_CH  output  4  channel tag of DATA.
REQ-015 DATA_VALID  output  1  one-cycle strobe marking new DATA/DATA_CH.
REQ-016 BUSY  output  1  high whenever the FSM is not in IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, CONVST, WAIT_CONV, SHIFT and DONE.
REQ-018 IDLE -> CONVST on a cycle with ENABLE=1; otherwise the FSM stays in IDLE.
REQ-019 CONVST: ADC_CONVST=1 for exactly CONVST_CYCLES cycles, then -> WAIT_CONV.
REQ-020 WAIT_CONV: ADC_CONVST=0 and ADC_SCK=0 for exactly CONV_CYCLES cycles, then -> SHIFT.
REQ-021 SHIFT: exactly 12 ADC_SCK periods, each CLK_DIV cycles low followed by CLK_DIV cycles high; ADC_SCK starts and ends low.
REQ-022 ADC_SDO SHALL be sampled on the CLOCK_50 edge that drives ADC_SCK 0->1, shifted in MSB first; the 1st sample is DATA[11] and the 12th is DATA[0].
REQ-023 After the 12th high phase completes: -> DONE; DATA is loaded from the shift register, DATA_VALID=1 for exactly one cycle, and DATA is held until the next DONE.
REQ-024 DONE -> CONVST if ENABLE=1, else -> IDLE; DONE always lasts exactly one cycle.
REQ-025 Frame length SHALL be CONVST_CYCLES + CONV_CYCLES + 24*CLK_DIV + 1 cycles (131 at defaults).
REQ-026 FLAG SHALL be 1 in CONVST, WAIT_CONV and SHIFT, and 0 in IDLE and DONE, so that it falls once per frame at DONE.
REQ-027 A 4-bit frame counter SHALL increment at each DONE and wrap from NUM_CH-1 to 0.
REQ-028 The ADC returns the result of the previous frame's configuration, so DATA_CH SHALL equal (counter-1) mod NUM_CH, evaluated before the DONE increment.
REQ-029 Deasserting ENABLE mid-frame SHALL NOT abort the frame: the frame completes with DATA_VALID and then goes to IDLE.
REQ-030 Asserting ENABLE during DONE SHALL continue directly into CONVST with no IDLE cycle.
REQ-031 Output width rules: DATA is 12-bit unsigned; DATA_CH upper bits are 0 when NUM_CH<=8.

Reset
REQ-032 While RESET_n=0, asynchronously: FSM=IDLE, ADC_CONVST=0, ADC_SCK=0, FLAG=0, DATA=0, DATA_CH=0, DATA_VALID=0, BUSY=0, frame counter=0, shift register and timers=0.
REQ-033 Reset asserted mid-frame SHALL abort the frame immediately with no DATA_VALID; operation resumes from IDLE on the first rising edge after RESET_n=1.

Verification
REQ-034 Single frame at defaults, ADC model returning 12'hA5C, ENABLE pulsed for 1 cycle -> CONVST high 2 cycles, 80-cycle gap, 12 SCK periods of 4 cycles each, DATA=12'hA5C, DATA_VALID one cycle at cycle 131, DATA_CH=12.
REQ-035 ENABLE held high for 14 frames, model returning 12'h000 and 12'hFFF alternately -> frames back-to-back with no IDLE cycle, DATA alternates correctly, DATA_CH sequence 12,0,1,...,12; 14 FLAG falling edges.
REQ-036 ENABLE dropped during SHIFT -> current frame completes with DATA_VALID, then FSM in IDLE with BUSY=0 and FLAG=0.
REQ-037 RESET_n pulsed low during WAIT_CONV -> all outputs return to reset values asynchronously, no DATA_VALID; the next frame's DATA_CH=12.
REQ-038 CLK_DIV=1, CONVST_CYCLES=1, CONV_CYCLES=1 -> frame length 27 cycles, SCK period 2 cycles, 12'h801 captured bit-exact.

Source files
------------

// File: rtl/adc_sdo_reader.sv
`timescale 1ns/1ps
// adc_sdo_reader: runs conversion frames on a serial 12-bit ADC. Each frame
// pulses ADC_CONVST, waits out the conversion, clocks 12 result bits in MSB
// first on ADC_SCK, then presents the word on DATA with a one-cycle strobe.
// The result carries the channel configured by the previous frame, so the tag
// lags the frame counter by one.
module adc_sdo_reader #(
  parameter int CLK_DIV       = 2,
  parameter int CONVST_CYCLES = 2,
  parameter int CONV_CYCLES   = 80,
  parameter int NUM_CH        = 13
) (
  input  logic        CLOCK_50,
  input  logic        RESET_n,
  input  logic        ENABLE,
  input  logic        ADC_SDO,
  output logic        ADC_CONVST,
  output logic        ADC_SCK,
  output logic        FLAG,
  output logic [11:0] DATA,
  output logic [3:0]  DATA_CH,
  output logic        DATA_VALID,
  output logic        BUSY
);

  localparam logic [9:0] LP_CONVST_LAST = 10'(CONVST_CYCLES - 1);
  localparam logic [9:0] LP_CONV_LAST   = 10'(CONV_CYCLES - 1);
  localparam logic [7:0] LP_DIV_LAST    = 8'(CLK_DIV - 1);
  localparam logic [3:0] LP_CH_LAST     = 4'(NUM_CH - 1);
  localparam logic [3:0] LP_BIT_LAST    = 4'd11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONVST,
    S_WAIT_CONV,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t      r_state;
  logic [9:0]  r_tmr;    // cycle timer for CONVST and WAIT_CONV
  logic [7:0]  r_div;    // cycles elapsed in the current SCK half-period
  logic [3:0]  r_bit;    // SCK period index within SHIFT
  logic [11:0] r_shift;  // incoming serial bits, MSB first
  logic [3:0]  r_frame;  // channel the current frame is configuring

  logic [3:0]  w_prev_ch;
  logic [3:0]  w_next_frame;

  // The word arriving now belongs to the channel set up one frame earlier.
  assign w_prev_ch    = (r_frame == 4'd0) ? LP_CH_LAST : (r_frame - 4'd1);
  assign w_next_frame = (r_frame == LP_CH_LAST) ? 4'd0 : (r_frame + 4'd1);

  // Frame sequencer; every output is registered and changes with the state.
  always_ff @(posedge CLOCK_50 or negedge RESET_n) begin
    if (!RESET_n) begin
      r_state    <= S_IDLE;
      r_tmr      <= '0;
      r_div      <= '0;
      r_bit      <= '0;
      r_shift    <= '0;
      r_frame    <= '0;
      ADC_CONVST <= 1'b0;
      ADC_SCK    <= 1'b0;
      FLAG       <= 1'b0;
      DATA       <= '0;
      DATA_CH    <= '0;
      DATA_VALID <= 1'b0;
      BUSY       <= 1'b0;
    end else begin
      DATA_VALID <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (ENABLE) begin
            r_state    <= S_CONVST;
            r_tmr      <= '0;
            ADC_CONVST <= 1'b1;
            FLAG       <= 1'b1;
            BUSY       <= 1'b1;
          end
        end
        S_CONVST: begin
          if (r_tmr == LP_CONVST_LAST) begin
            r_state    <= S_WAIT_CONV;
            r_tmr      <= '0;
            ADC_CONVST <= 1'b0;
          end else begin
            r_tmr <= r_tmr + 10'd1;
          end
        end
        S_WAIT_CONV: begin
          if (r_tmr == LP_CONV_LAST) begin
            r_state <= S_SHIFT;
            r_tmr   <= '0;
            r_div   <= '0;
            r_bit   <= '0;
          end else begin
            r_tmr <= r_tmr + 10'd1;
          end
        end
        S_SHIFT: begin
          if (r_div == LP_DIV_LAST) begin
            r_div <= '0;
            if (!ADC_SCK) begin
              // SDO settled on the previous SCK fall; take it as SCK rises.
              ADC_SCK <= 1'b1;
              r_shift <= {r_shift[10:0], ADC_SDO};
            end else begin
              ADC_SCK <= 1'b0;
              if (r_bit == LP_BIT_LAST) begin
                r_state    <= S_DONE;
                FLAG       <= 1'b0;
                DATA       <= r_shift;
                DATA_CH    <= w_prev_ch;
                DATA_VALID <= 1'b1;
                r_frame    <= w_next_frame;
              end else begin
                r_bit <= r_bit + 4'd1;
              end
            end
          end else begin
            r_div <= r_div + 8'd1;
          end
        end
        S_DONE: begin
          if (ENABLE) begin
            r_state    <= S_CONVST;
            r_tmr      <= '0;
            ADC_CONVST <= 1'b1;
            FLAG       <= 1'b1;
          end else begin
            r_state <= S_IDLE;
            BUSY    <= 1'b0;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          ADC_CONVST <= 1'b0;
          ADC_SCK    <= 1'b0;
          FLAG       <= 1'b0;
          BUSY       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_sdo_reader.sv
`timescale 1ns/1ps
// Bench for adc_sdo_reader: two instances (default timing and the fastest
// timing), a serial ADC model per instance, and a frame-timeline model that
// predicts every output cycle by cycle.
module tb_adc_sdo_reader;

  localparam int A_CV = 2;
  localparam int A_CC = 80;
  localparam int A_D  = 2;
  localparam int B_CV = 1;
  localparam int B_CC = 1;
  localparam int B_D  = 1;
  localparam int NCH  = 13;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  en;
  logic [1:0]  sdo;
  logic [1:0]  convst;
  logic [1:0]  sck;
  logic [1:0]  flag;
  logic [1:0]  valid;
  logic [1:0]  busy;
  logic [11:0] data [2];
  logic [3:0]  dch  [2];

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  adc_sdo_reader u_a (
    .CLOCK_50(clk), .RESET_n(rst_n), .ENABLE(en[0]), .ADC_SDO(sdo[0]),
    .ADC_CONVST(convst[0]), .ADC_SCK(sck[0]), .FLAG(flag[0]),
    .DATA(data[0]), .DATA_CH(dch[0]), .DATA_VALID(valid[0]), .BUSY(busy[0])
  );

  adc_sdo_reader #(.CLK_DIV(1), .CONVST_CYCLES(1), .CONV_CYCLES(1)) u_b (
    .CLOCK_50(clk), .RESET_n(rst_n), .ENABLE(en[1]), .ADC_SDO(sdo[1]),
    .ADC_CONVST(convst[1]), .ADC_SCK(sck[1]), .FLAG(flag[1]),
    .DATA(data[1]), .DATA_CH(dch[1]), .DATA_VALID(valid[1]), .BUSY(busy[1])
  );

  // Words the ADC returns, one per started frame, in order.
  logic [11:0] tbl_a [32];
  logic [11:0] tbl_b [4];

  // ADC models: a new word loads when CONVST rises; each SCK fall exposes the next bit.
  int fa = 0;
  int fb = 0;
  logic [11:0] sh_a = 12'h000;
  logic [11:0] sh_b = 12'h000;

  always @(posedge convst[0] or negedge sck[0])
    if (convst[0]) begin
      sh_a <= tbl_a[fa[4:0]];
      fa   <= fa + 1;
    end else begin
      sh_a <= {sh_a[10:0], 1'b0};
    end

  always @(posedge convst[1] or negedge sck[1])
    if (convst[1]) begin
      sh_b <= tbl_b[fb[1:0]];
      fb   <= fb + 1;
    end else begin
      sh_b <= {sh_b[10:0], 1'b0};
    end

  assign sdo[0] = sh_a[11];
  assign sdo[1] = sh_b[11];

  function automatic int p_cv(int k);  return (k == 0) ? A_CV : B_CV; endfunction
  function automatic int p_cc(int k);  return (k == 0) ? A_CC : B_CC; endfunction
  function automatic int p_d(int k);   return (k == 0) ? A_D  : B_D;  endfunction
  function automatic int p_len(int k); return p_cv(k) + p_cc(k) + 24 * p_d(k) + 1; endfunction

  function automatic logic [11:0] word_of(int k, int f);
    return (k == 0) ? tbl_a[f[4:0]] : tbl_b[f[1:0]];
  endfunction

  // Timeline model: a frame is a run of p_len cycles indexed by m_t.
  logic        m_in   [2];
  int          m_t    [2];
  int          m_cnt  [2];
  int          m_f    [2] = '{0, 0};
  logic [11:0] m_word [2];
  logic [11:0] m_data [2];
  logic [3:0]  m_ch   [2];

  always @(posedge clk or negedge rst_n)
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_in[k]   <= 1'b0;
        m_t[k]    <= 0;
        m_cnt[k]  <= 0;
        m_data[k] <= 12'h000;
        m_ch[k]   <= 4'd0;
      end else if (!m_in[k]) begin
        if (en[k]) begin
          m_in[k]   <= 1'b1;
          m_t[k]    <= 0;
          m_word[k] <= word_of(k, m_f[k]);
          m_f[k]    <= m_f[k] + 1;
        end
      end else if (m_t[k] == p_len(k) - 1) begin
        if (en[k]) begin
          m_t[k]    <= 0;
          m_word[k] <= word_of(k, m_f[k]);
          m_f[k]    <= m_f[k] + 1;
        end else begin
          m_in[k] <= 1'b0;
        end
      end else begin
        m_t[k] <= m_t[k] + 1;
        if (m_t[k] == p_len(k) - 2) begin
          m_data[k] <= m_word[k];
          m_ch[k]   <= 4'((m_cnt[k] + NCH - 1) % NCH);
          m_cnt[k]  <= (m_cnt[k] + 1) % NCH;
        end
      end
    end

  task automatic chk(string nm, int act, int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic cmp_model();
    for (int k = 0; k < 2; k++) begin
      int t   = m_t[k];
      int cv  = p_cv(k);
      int cc  = p_cc(k);
      int d   = p_d(k);
      int len = p_len(k);
      int e_cv, e_fl, e_vl, e_sck, e_busy;
      e_busy = m_in[k] ? 1 : 0;
      e_cv   = (m_in[k] && t < cv) ? 1 : 0;
      e_fl   = (m_in[k] && t < len - 1) ? 1 : 0;
      e_vl   = (m_in[k] && t == len - 1) ? 1 : 0;
      e_sck  = (m_in[k] && t >= cv + cc && t < len - 1 && ((t - cv - cc) / d) % 2 == 1) ? 1 : 0;
      chk($sformatf("m%0d_convst t=%0d", k, t), int'(convst[k]), e_cv);
      chk($sformatf("m%0d_sck t=%0d", k, t), int'(sck[k]), e_sck);
      chk($sformatf("m%0d_flag t=%0d", k, t), int'(flag[k]), e_fl);
      chk($sformatf("m%0d_valid t=%0d", k, t), int'(valid[k]), e_vl);
      chk($sformatf("m%0d_busy t=%0d", k, t), int'(busy[k]), e_busy);
      chk($sformatf("m%0d_data", k), int'(data[k]), int'(m_data[k]));
      chk($sformatf("m%0d_ch", k), int'(dch[k]), int'(m_ch[k]));
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cmp_model();
  endtask

  initial begin
    int vat, nval, ncv, nrise, r1, r2, nfall, idle, bad;
    logic [11:0] vdata;
    logic [3:0]  vch;
    logic        prev;

    rst_n = 1'b0;
    en    = 2'b00;
    for (int i = 0; i < 32; i++) tbl_a[i] = 12'h000;
    tbl_a[0] = 12'hA5C;
    for (int i = 1; i <= 14; i++) tbl_a[i] = (i % 2 == 1) ? 12'h000 : 12'hFFF;
    tbl_a[15] = 12'h3C7;
    tbl_a[16] = 12'h123;
    tbl_a[17] = 12'h9B6;
    tbl_b[0] = 12'h801;
    for (int i = 1; i < 4; i++) tbl_b[i] = 12'h7FE;

    repeat (3) tick();
    chk("rst_data", int'(data[0]), 0);
    chk("rst_ch", int'(dch[0]), 0);
    chk("rst_busy", int'(busy[0]), 0);
    chk("rst_flag", int'(flag[0]), 0);
    chk("rst_convst", int'(convst[0]), 0);
    chk("rst_sck", int'(sck[0]), 0);
    chk("rst_valid", int'(valid[0]), 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Single frame at default timing, ENABLE for one cycle.
    en[0] = 1'b1;
    vat = 0; nval = 0; ncv = 0; nrise = 0; r1 = 0; prev = 1'b0; vdata = '0; vch = '0;
    for (int n = 1; n <= 300; n++) begin
      tick();
      en[0] = 1'b0;
      if (convst[0]) ncv++;
      if (sck[0] && !prev) begin nrise++; if (r1 == 0) r1 = n; end
      prev = sck[0];
      if (valid[0]) begin nval++; vat = n; vdata = data[0]; vch = dch[0]; end
      if (vat != 0 && !busy[0]) break;
    end
    chk("t1_valid_cycle", vat, 131);
    chk("t1_valid_count", nval, 1);
    chk("t1_convst_cycles", ncv, 2);
    chk("t1_sck_rises", nrise, 12);
    chk("t1_first_rise", r1, 85);
    chk("t1_data", int'(vdata), 'hA5C);
    chk("t1_ch", int'(vch), 12);

    // Fourteen back-to-back frames after a fresh reset.
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    en[0] = 1'b1;
    nval = 0; nfall = 0; idle = 0; bad = 0; prev = 1'b0;
    for (int n = 1; n <= 2000; n++) begin
      tick();
      if (nval == 13 && !valid[0]) en[0] = 1'b0;
      if (!busy[0] && nval < 14) idle++;
      if (prev && !flag[0]) nfall++;
      prev = flag[0];
      if (valid[0]) begin
        nval++;
        if (data[0] != ((nval % 2 == 1) ? 12'h000 : 12'hFFF)) bad++;
        if (int'(dch[0]) != (nval + 11) % 13) bad++;
      end
      if (nval == 14 && !busy[0]) break;
    end
    en[0] = 1'b0;
    chk("t2_valid_count", nval, 14);
    chk("t2_flag_falls", nfall, 14);
    chk("t2_idle_cycles", idle, 0);
    chk("t2_bad_frames", bad, 0);
    chk("t2_last_data", int'(data[0]), 'hFFF);
    chk("t2_last_ch", int'(dch[0]), 12);

    // ENABLE dropped once the frame is shifting.
    repeat (3) tick();
    en[0] = 1'b1;
    nval = 0; vdata = '0; vch = '0;
    for (int n = 1; n <= 300; n++) begin
      tick();
      if (sck[0]) en[0] = 1'b0;
      if (valid[0]) begin nval++; vdata = data[0]; vch = dch[0]; end
      if (nval != 0 && !busy[0]) break;
    end
    en[0] = 1'b0;
    chk("t3_valid_count", nval, 1);
    chk("t3_data", int'(vdata), 'h3C7);
    chk("t3_ch", int'(vch), 0);
    chk("t3_busy", int'(busy[0]), 0);
    chk("t3_flag", int'(flag[0]), 0);
    repeat (5) tick();
    chk("t3_stays_idle", int'(busy[0]), 0);

    // Reset pulse in the middle of the conversion wait.
    en[0] = 1'b1;
    tick();
    en[0] = 1'b0;
    repeat (39) tick();
    chk("t4_pre_busy", int'(busy[0]), 1);
    chk("t4_pre_convst", int'(convst[0]), 0);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_async_busy", int'(busy[0]), 0);
    chk("t4_async_flag", int'(flag[0]), 0);
    chk("t4_async_data", int'(data[0]), 0);
    chk("t4_async_ch", int'(dch[0]), 0);
    chk("t4_async_convst", int'(convst[0]), 0);
    chk("t4_async_sck", int'(sck[0]), 0);
    tick();
    rst_n = 1'b1;
    nval = 0;
    for (int n = 1; n <= 200; n++) begin
      tick();
      if (valid[0]) nval++;
    end
    chk("t4_no_valid", nval, 0);
    en[0] = 1'b1;
    nval = 0; vdata = '0; vch = '0;
    for (int n = 1; n <= 300; n++) begin
      tick();
      en[0] = 1'b0;
      if (valid[0]) begin nval++; vdata = data[0]; vch = dch[0]; end
      if (nval != 0 && !busy[0]) break;
    end
    chk("t4_next_data", int'(vdata), 'h9B6);
    chk("t4_next_ch", int'(vch), 12);

    // Fastest timing on the second instance.
    en[1] = 1'b1;
    vat = 0; nrise = 0; r1 = 0; r2 = 0; prev = 1'b0; vdata = '0; vch = '0;
    for (int n = 1; n <= 100; n++) begin
      tick();
      en[1] = 1'b0;
      if (sck[1] && !prev) begin
        nrise++;
        if (r1 == 0) r1 = n;
        else if (r2 == 0) r2 = n;
      end
      prev = sck[1];
      if (valid[1]) begin vat = n; vdata = data[1]; vch = dch[1]; end
      if (vat != 0 && !busy[1]) break;
    end
    chk("t5_valid_cycle", vat, 27);
    chk("t5_data", int'(vdata), 'h801);
    chk("t5_ch", int'(vch), 12);
    chk("t5_first_rise", r1, 4);
    chk("t5_sck_period", r2 - r1, 2);
    chk("t5_sck_rises", nrise, 12);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
